// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and widths for the debounce filter
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b10,
        WAIT_LO = 2'b11
    } state_e;

    localparam int GLITCH_CNT_W = 8;

    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous bit
module sync2 (
    input  logic d,
    output logic q,
    input  logic clk,
    input  logic rst_n
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - debounce FSM with rise pulse; DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_raw,
    output logic sig_clean,
    output logic sig_rise,
    output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic           sig_sync;
    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           rise_q, rise_d;

    sync2 u_sync2 (
        .d     (sig_raw),
        .q     (sig_sync),
        .clk   (clk),
        .rst_n (rst_n)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE_LO: if (sig_sync) begin
                state_d = WAIT_HI;
                cnt_d   = '0;
            end
            WAIT_HI: begin
                if (!sig_sync)             state_d = IDLE_LO;
                else if (cnt_q == CNT_LAST) state_d = IDLE_HI;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            IDLE_HI: if (!sig_sync) begin
                state_d = WAIT_LO;
                cnt_d   = '0;
            end
            WAIT_LO: begin
                if (sig_sync)              state_d = IDLE_HI;
                else if (cnt_q == CNT_LAST) state_d = IDLE_LO;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE_LO;
        endcase
        rise_d = (state_q == WAIT_HI) && (state_d == IDLE_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    // Encoding puts the accepted level in bit 1 and "qualifying" in bit 0.
    assign sig_clean = state_q[1];
    assign busy      = state_q[0];
    assign sig_rise  = rise_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                    reject;
    logic [GLITCH_CNT_W-1:0] glitch_q;

    // A waiting state that sees the accepted level again has been rejected.
    assign reject = busy && (sig_sync == sig_clean);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        glitch_q <= '0;
        else if (reject && (glitch_q != '1)) glitch_q <= glitch_q + 1'b1;
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
